// File: rtl/bus_pkg.sv
// Shared defaults and lane-slicing helper for the bus mux family.
package bus_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SEL_BIT    = 3;

    // LSB position of lane 'lane' in a packed bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bus_xbar_lane.sv
// One crossbar output lane: select/scan state plus the registered output mux.
module bus_xbar_lane
    import bus_pkg::*;
#(
    parameter int NUM_INPUT   = 8,
    parameter int SEL_BIT     = DEF_SEL_BIT,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_INPUT-1:0]            valid_in,
    input  logic                            wr,
    input  logic [SEL_BIT-1:0]              cfg_sel,
    input  logic                            cfg_scan,
    input  logic [DWELL_WIDTH-1:0]          dwell,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic [SEL_BIT-1:0]              sel
);

    logic [SEL_BIT-1:0]     sel_r;
    logic                   scan_r;
    logic [DWELL_WIDTH-1:0] cnt_r;
    logic [DATA_WIDTH-1:0]  pick_data;
    logic                   pick_valid;
    logic                   sel_last;

    // Selects with no matching input fall through to zero data and valid.
    always_comb begin
        pick_data  = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (sel_r == SEL_BIT'(i)) begin
                pick_data  = data_in[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
                pick_valid = valid_in[i];
            end
        end
    end

    assign sel_last = int'(sel_r) >= NUM_INPUT - 1;
    assign sel      = sel_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_r     <= '0;
            scan_r    <= 1'b0;
            cnt_r     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            data_out  <= pick_data;
            valid_out <= pick_valid;
            if (wr) begin
                sel_r  <= cfg_sel;
                scan_r <= cfg_scan;
                cnt_r  <= '0;
            end else if (scan_r) begin
                // Exact match only: a lowered dwell is reached after wrap.
                if (cnt_r == dwell) begin
                    cnt_r <= '0;
                    sel_r <= sel_last ? '0 : sel_r + SEL_BIT'(1);
                end else begin
                    cnt_r <= cnt_r + DWELL_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bus_xbar.sv
// Registered crossbar: config-address decode and packing around per-lane selectors.
module bus_xbar
    import bus_pkg::*;
#(
    parameter int NUM_INPUT   = 8,
    parameter int NUM_OUTPUT  = 8,
    parameter int SEL_BIT     = DEF_SEL_BIT,
    parameter int OUT_SEL_BIT = 3,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_INPUT-1:0]             valid_in,
    input  logic                             cfg_we,
    input  logic [OUT_SEL_BIT-1:0]           cfg_addr,
    input  logic [SEL_BIT-1:0]               cfg_sel,
    input  logic                             cfg_scan,
    input  logic [DWELL_WIDTH-1:0]           dwell,
    output logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out,
    output logic [NUM_OUTPUT-1:0]            valid_out,
    output logic [NUM_OUTPUT*SEL_BIT-1:0]    sel_out
);

    for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_lane
        // Addresses at or beyond NUM_OUTPUT match no lane and are dropped.
        logic wr;
        assign wr = cfg_we && (cfg_addr == OUT_SEL_BIT'(o));

        bus_xbar_lane #(
            .NUM_INPUT  (NUM_INPUT),
            .SEL_BIT    (SEL_BIT),
            .DATA_WIDTH (DATA_WIDTH),
            .DWELL_WIDTH(DWELL_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .data_in  (data_in),
            .valid_in (valid_in),
            .wr       (wr),
            .cfg_sel  (cfg_sel),
            .cfg_scan (cfg_scan),
            .dwell    (dwell),
            .data_out (data_out[lane_lsb(o, DATA_WIDTH) +: DATA_WIDTH]),
            .valid_out(valid_out[o]),
            .sel      (sel_out[lane_lsb(o, SEL_BIT) +: SEL_BIT])
        );
    end

endmodule

// File: tb/tb_bus_xbar.sv
// Directed bench for bus_xbar: an 8x8 instance plus a 6x6 instance for range limits.
module tb_bus_xbar;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data_in;
    logic [7:0]  valid_in;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [2:0]  cfg_sel;
    logic        cfg_scan;
    logic [7:0]  dwell;
    logic [63:0] data_out;
    logic [7:0]  valid_out;
    logic [23:0] sel_out;
    logic [47:0] data_out6;
    logic [5:0]  valid_out6;
    logic [17:0] sel_out6;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_xbar dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_scan(cfg_scan),
        .dwell(dwell), .data_out(data_out), .valid_out(valid_out), .sel_out(sel_out)
    );

    bus_xbar #(.NUM_INPUT(6), .NUM_OUTPUT(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in[47:0]), .valid_in(valid_in[5:0]),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_scan(cfg_scan),
        .dwell(dwell), .data_out(data_out6), .valid_out(valid_out6), .sel_out(sel_out6)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [2:0] sel, input logic scan);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_sel  = sel;
        cfg_scan = scan;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        logic [23:0] exp_sel;
        int scan_seq[10];
        scan_seq = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};

        rst_n    = 1'b0;
        data_in  = 64'h88F6E5D4C3B2A100;
        valid_in = 8'hFF;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_sel  = '0;
        cfg_scan = 1'b0;
        dwell    = 8'd0;
        tick();
        tick();
        check("reset_data", data_out, 64'h0);
        check("reset_valid", {56'h0, valid_out}, 64'h0);
        check("reset_sel", {40'h0, sel_out}, 64'h0);
        rst_n = 1'b1;
        tick();
        check("idle_data", data_out, 64'h0);
        check("idle_sel", {40'h0, sel_out}, 64'h0);

        // Static select on one lane
        cfg_write(3'd3, 3'd5, 1'b0);
        check("lane3_sel", {61'h0, sel_out[11:9]}, 64'd5);
        check("lane3_data_lag", data_out, 64'h0);
        tick();
        check("lane3_data", data_out, 64'h00000000E5000000);
        check("lane3_valid", {56'h0, valid_out}, 64'hFF);

        // Reverse all lanes
        for (int o = 0; o < 8; o++) cfg_write(3'(o), 3'(7 - o), 1'b0);
        tick();
        exp_sel = '0;
        for (int o = 0; o < 8; o++) exp_sel[o*3 +: 3] = 3'(7 - o);
        check("reverse_sel", {40'h0, sel_out}, {40'h0, exp_sel});
        check("reverse_data", data_out, 64'h00A1B2C3D4E5F688);
        valid_in = 8'hFB;
        tick();
        check("valid_drop", {56'h0, valid_out}, 64'hDF);
        valid_in = 8'hFF;

        // Scan with dwell 2, then dwell 0
        dwell = 8'd2;
        cfg_write(3'd0, 3'd6, 1'b1);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) tick();
            check($sformatf("scan_d2_%0d", j), {61'h0, sel_out[2:0]}, 64'(scan_seq[j]));
        end
        dwell = 8'd0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("scan_d0_%0d", j), {61'h0, sel_out[2:0]}, 64'(2 + j));
        end

        // Config write on the advance cycle wins and restarts the count
        dwell = 8'd2;
        tick();
        tick();
        check("pre_collide", {61'h0, sel_out[2:0]}, 64'd5);
        cfg_write(3'd0, 3'd2, 1'b1);
        check("collide_sel", {61'h0, sel_out[2:0]}, 64'd2);
        tick();
        check("collide_hold1", {61'h0, sel_out[2:0]}, 64'd2);
        tick();
        check("collide_hold2", {61'h0, sel_out[2:0]}, 64'd2);
        tick();
        check("collide_adv", {61'h0, sel_out[2:0]}, 64'd3);

        // Reset mid-scan with a concurrent write
        rst_n    = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = 3'd4;
        cfg_sel  = 3'd3;
        cfg_scan = 1'b1;
        tick();
        rst_n  = 1'b1;
        cfg_we = 1'b0;
        check("rst_mid_data", data_out, 64'h0);
        check("rst_mid_valid", {56'h0, valid_out}, 64'h0);
        check("rst_mid_sel", {40'h0, sel_out}, 64'h0);
        check("rst_mid_sel6", {46'h0, sel_out6}, 64'h0);
        for (int j = 0; j < 5; j++) tick();
        check("rst_static_sel", {40'h0, sel_out}, 64'h0);
        check("rst_static_data", data_out, 64'h0);
        check("rst_static_valid", {56'h0, valid_out}, 64'hFF);

        // Out-of-range select and address on the 6x6 instance
        cfg_write(3'd2, 3'd4, 1'b0);
        cfg_write(3'd1, 3'd7, 1'b0);
        tick();
        check("oor_sel6", {46'h0, sel_out6}, 64'h138);
        check("oor_data6", {16'h0, data_out6}, 64'h000000D40000);
        check("oor_valid6", {58'h0, valid_out6}, 64'b111101);
        cfg_write(3'd7, 3'd3, 1'b1);
        tick();
        check("bad_addr_sel6", {46'h0, sel_out6}, 64'h138);
        check("bad_addr_data6", {16'h0, data_out6}, 64'h000000D40000);

        // Scan wrap at NUM_INPUT-1 on the 6x6 instance
        dwell = 8'd0;
        cfg_write(3'd3, 3'd5, 1'b1);
        check("wrap6_5", {61'h0, sel_out6[11:9]}, 64'd5);
        tick();
        check("wrap6_0", {61'h0, sel_out6[11:9]}, 64'd0);
        tick();
        check("wrap6_1", {61'h0, sel_out6[11:9]}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_xbar.md
# bus_xbar

Parametrised registered crossbar: the successor to the single-select bus mux. Each of NUM_OUTPUT output lanes independently selects one of NUM_INPUT packed input lanes and carries a per-lane valid bit. Each lane holds its own select register, loaded through a one-lane-per-cycle config port. A lane can be put in scan mode, where its select steps through all inputs with a programmable dwell time. It sits between the packed data sources and the consumers on the board data path; all outputs are registered.

## Interface
- NUM_INPUT, 8: number of input lanes
- NUM_OUTPUT, 8: number of output lanes
- SEL_BIT, 3: input-select width; must satisfy 2^SEL_BIT >= NUM_INPUT
- OUT_SEL_BIT, 3: config-address width; must satisfy 2^OUT_SEL_BIT >= NUM_OUTPUT
- DATA_WIDTH, 8: bits per lane
- DWELL_WIDTH, 8: dwell counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- data_in  in  NUM_INPUT*DATA_WIDTH  packed inputs; lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- valid_in  in  NUM_INPUT  per-input valid
- cfg_we  in  1  config write strobe
- cfg_addr  in  OUT_SEL_BIT  target output lane
- cfg_sel  in  SEL_BIT  new select for target lane
- cfg_scan  in  1  1 = scan mode for target lane
- dwell  in  DWELL_WIDTH  global scan dwell; sampled every cycle
- data_out  out  NUM_OUTPUT*DATA_WIDTH  packed outputs, same lane packing as data_in
- valid_out  out  NUM_OUTPUT  per-output valid
- sel_out  out  NUM_OUTPUT*SEL_BIT  current select register of each lane

## Operation
- Per-lane state:
  - sel_r (SEL_BIT bits)
  - scan_r (1 bit)
  - cnt_r (DWELL_WIDTH bits)
- Data path, per lane o, each cycle:
  - data_out[o] <= data_in[sel_r[o]]
  - valid_out[o] <= valid_in[sel_r[o]]
  - If sel_r[o] >= NUM_INPUT: data_out[o] <= 0 and valid_out[o] <= 0.
- Config write, when cfg_we=1 and cfg_addr < NUM_OUTPUT, for lane cfg_addr:
  - sel_r <= cfg_sel
  - scan_r <= cfg_scan
  - cnt_r <= 0
- Config write with cfg_addr >= NUM_OUTPUT is ignored; no state changes.
- Scan mode (scan_r=1, no config write to this lane this cycle):
  - If cnt_r == dwell: cnt_r <= 0 and sel_r advances. sel_r <= sel_r+1, except sel_r >= NUM_INPUT-1 gives sel_r <= 0.
  - Otherwise cnt_r <= cnt_r+1.
  - dwell=0 means advance every cycle.
  - dwell lowered below cnt_r mid-count: cnt_r continues counting up, wraps at 2^DWELL_WIDTH, then matches dwell. No early advance.
- Static mode (scan_r=0): sel_r and cnt_r hold.
- A config write to a lane overrides that lane's scan advance in the same cycle. Other lanes are unaffected.
- sel_out mirrors sel_r combinationally from the register; there is no extra stage.

## Timing
- Reset (rst_n=0 at an edge): all sel_r=0, scan_r=0, cnt_r=0, data_out=0, valid_out=0, sel_out=0. Reset overrides cfg_we.
- Reset asserted mid-scan: state clears at that edge. Scanning resumes only after a new config write.
- Input-to-output latency is 1 cycle: data_in at edge k appears on data_out after edge k.
- Config latency:
  - A write sampled at edge k updates sel_out after edge k.
  - data_out reflects the new source after edge k+1.
- Scan latency: the advance happens at the edge where cnt_r==dwell. A lane therefore holds each select for dwell+1 cycles.
- No backpressure. Outputs update every cycle.

## Structure
- Shared package/header bus_pkg holds:
  - default widths (DATA_WIDTH, SEL_BIT)
  - the lane-slice helper constant/function shared with bus_mux
- One sub-module, bus_xbar_lane, per output lane: sel_r/scan_r/cnt_r, scan logic, output register. It is generated NUM_OUTPUT times.
- The top level performs config-address decode and packs/unpacks the lanes.

## Test plan
Common stimulus: data_in lanes 0..7 = 00,A1,B2,C3,D4,E5,F6,88; valid_in = 8'hFF unless stated.

- Reset and static select:
  - Stimulus: release rst_n, then no writes.
  - Required: all data_out lanes = 00 one cycle later, and sel_out=0.
  - Stimulus: write lane 3 with sel=5, scan=0.
  - Required: sel_out[3]=5 after the write edge; data_out[3]=E5 one edge later; other lanes stay 00.
- Per-lane independence:
  - Stimulus: write lane o with sel=7-o, for o=0..7.
  - Required: data_out = 00,A1,...,88 reversed (lane 0 = 88, lane 7 = 00).
  - Stimulus: clear valid_in[2].
  - Required: valid_out[5]=0 one cycle later.
- Scan with dwell:
  - Stimulus: dwell=2; write lane 0 with sel=6, scan=1.
  - Required: sel_out[0] sequence 6,6,6,7,7,7,0,0,0,1,... (3 cycles each, wraps 7->0).
  - Stimulus: dwell=0.
  - Required: lane 0 advances every cycle.
- Simultaneous write and scan advance:
  - Stimulus: write lane 0 with sel=2, scan=1 on the cycle its cnt_r==dwell.
  - Required: sel_out[0]=2 (no increment) and cnt_r restarts at 0.
- Out-of-range:
  - Stimulus: NUM_INPUT=6; write lane 1 with sel=7.
  - Required: data_out[1]=0, valid_out[1]=0.
  - Stimulus: NUM_OUTPUT=6; write cfg_addr=7.
  - Required: no lane changes.
  - Stimulus: scan from sel=5 with NUM_INPUT=6.
  - Required: sel wraps to 0.
- Reset mid-scan:
  - Stimulus: assert rst_n=0 for 1 cycle during scan, with cfg_we=1 in the same cycle.
  - Required: all outputs 0, scan_r=0, the write is discarded, and lanes stay static afterwards.
